lcd_char_ctrl: RTL



---
 rtl/lcd_char_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_char_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_char_ctrl
//   HD44780-class character LCD controller (8-bit bus, write-only).
//   Waits out the panel power-up time, issues the init command sequence, then
//   refreshes the panel forever from an internal ROWS x COLS character buffer.
//   Every command or character occupies one bus slot of SLOT_CYC clocks.
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   wr_en      : buffer write strobe (one cycle per write)
//   wr_addr    : buffer index = row*COLS + col; indices >= ROWS*COLS are ignored
//   wr_data    : character code to store
//   init_done  : high once the init sequence has completed
//   frame_done : one-cycle pulse after the last character of the last row
//   lcd_rs     : 0 = command, 1 = data
//   lcd_rw     : always 0 (write-only)
//   lcd_en     : enable strobe, high during the second half of each slot
//   lcd_data   : LCD data bus
// -----------------------------------------------------------------------------
module lcd_char_ctrl #(
    parameter int SLOT_CYC    = 100000,
    parameter int POWERUP_CYC = 750000,
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    localparam int DEPTH      = ROWS * COLS,
    // One extra bit when DEPTH is a power of two, so that out-of-range
    // indices can actually be presented and rejected.
    localparam int AW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          init_done,
    output logic          frame_done,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    output logic [7:0]    lcd_data
);
    localparam int SW = $clog2(SLOT_CYC);
    localparam int PW = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC + 1) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYC - 1);
    localparam logic [SW-1:0] SLOT_MID  = SW'(SLOT_CYC / 2 - 1);
    localparam logic [PW-1:0] PWR_LAST  = PW'(POWERUP_CYC);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic          ROW_LAST  = 1'(ROWS - 1);
    localparam logic [IW-1:0] COLS_I    = IW'(COLS);
    localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
    localparam logic [2:0]    INIT_LAST = 3'd4;

    typedef enum logic [1:0] {PWR_WAIT, INIT, ROW_ADDR, WRITE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  slot_cnt_q, slot_cnt_d;
    logic [PW-1:0]  pwr_cnt_q, pwr_cnt_d;
    logic [2:0]     init_idx_q, init_idx_d;
    logic           row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic           lcd_rs_q, lcd_rs_d;
    logic [7:0]     lcd_data_q, lcd_data_d;
    logic           lcd_en_q, lcd_en_d;
    logic           init_done_q, init_done_d;
    logic           frame_done_q, frame_done_d;
    logic [7:0]     mem_q [DEPTH];

    logic           boundary_s;
    logic           mid_s;
    logic           pwr_done_s;
    logic           wr_hit_s;
    logic [IW-1:0]  wr_idx_s;
    logic [CW-1:0]  rd_col_s;
    logic [IW-1:0]  rd_idx_s;
    logic [7:0]     rd_char_s;

    // Init command ROM: function set, display off, clear, entry mode, display on.
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0:    cmd = 8'h38;
            3'd1:    cmd = 8'h08;
            3'd2:    cmd = 8'h01;
            3'd3:    cmd = 8'h06;
            3'd4:    cmd = 8'h0C;
            default: cmd = 8'h0C;
        endcase
        return cmd;
    endfunction

    assign boundary_s = (slot_cnt_q == SLOT_LAST);
    assign mid_s      = (slot_cnt_q == SLOT_MID);
    assign pwr_done_s = (pwr_cnt_q == PWR_LAST);
    assign wr_hit_s   = wr_en && (wr_addr < DEPTH_A);
    assign wr_idx_s   = IW'(wr_addr);

    // Free-running slot timer and saturating power-up counter.
    always_comb begin
        if (boundary_s) begin
            slot_cnt_d = '0;
        end else begin
            slot_cnt_d = slot_cnt_q + SW'(1);
        end
        if (pwr_done_s) begin
            pwr_cnt_d = pwr_cnt_q;
        end else begin
            pwr_cnt_d = pwr_cnt_q + PW'(1);
        end
    end

    // Buffer read for the character that opens the next slot: column 0 after a
    // row address, otherwise the following column of the current row.
    always_comb begin
        if (state_q == WRITE) begin
            rd_col_s = col_q + CW'(1);
        end else begin
            rd_col_s = '0;
        end
        rd_idx_s  = (IW'(row_q) * COLS_I) + IW'(rd_col_s);
        rd_char_s = mem_q[rd_idx_s];
    end

    // Sequencer next state and bus contents; bus changes only at slot boundaries.
    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        row_d        = row_q;
        col_d        = col_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_data_d   = lcd_data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        if (boundary_s) begin
            lcd_en_d = 1'b0;
        end else if (mid_s && (state_q != PWR_WAIT)) begin
            lcd_en_d = 1'b1;
        end else begin
            lcd_en_d = lcd_en_q;
        end
        if (boundary_s) begin
            case (state_q)
                PWR_WAIT: begin
                    if (pwr_done_s) begin
                        state_d    = INIT;
                        init_idx_d = 3'd0;
                        lcd_rs_d   = 1'b0;
                        lcd_data_d = init_cmd(3'd0);
                    end else begin
                        state_d    = PWR_WAIT;
                    end
                end
                INIT: begin
                    if (init_idx_q == INIT_LAST) begin
                        state_d     = ROW_ADDR;
                        row_d       = 1'b0;
                        lcd_rs_d    = 1'b0;
                        lcd_data_d  = 8'h80;
                        init_done_d = 1'b1;
                    end else begin
                        init_idx_d  = init_idx_q + 3'd1;
                        lcd_data_d  = init_cmd(init_idx_q + 3'd1);
                    end
                end
                ROW_ADDR: begin
                    state_d    = WRITE;
                    col_d      = '0;
                    lcd_rs_d   = 1'b1;
                    lcd_data_d = rd_char_s;
                end
                WRITE: begin
                    if (col_q == COL_LAST) begin
                        state_d  = ROW_ADDR;
                        col_d    = '0;
                        lcd_rs_d = 1'b0;
                        if (row_q == ROW_LAST) begin
                            row_d        = 1'b0;
                            lcd_data_d   = 8'h80;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d        = 1'b1;
                            lcd_data_d   = 8'hC0;
                        end
                    end else begin
                        col_d      = col_q + CW'(1);
                        lcd_data_d = rd_char_s;
                    end
                end
                default: begin
                    state_d = PWR_WAIT;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Sequencer, timer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PWR_WAIT;
            slot_cnt_q   <= '0;
            pwr_cnt_q    <= '0;
            init_idx_q   <= 3'd0;
            row_q        <= 1'b0;
            col_q        <= '0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            lcd_en_q     <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            pwr_cnt_q    <= pwr_cnt_d;
            init_idx_q   <= init_idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
            lcd_en_q     <= lcd_en_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Character buffer; a write on a boundary cycle lands after the read above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h20;
            end
        end else if (wr_hit_s) begin
            mem_q[wr_idx_s] <= wr_data;
        end
    end

    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = lcd_en_q;
    assign lcd_data   = lcd_data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule
